auto_gain_ranger: RTL and testbench

Automatic range controller for the coarse gain-and-limiter stage. Monitors the signed pre-gain sum (adder output) and drives the limiter's log2 gain select.
- Each measurement window: steps gain up when there is headroom, down when the sample would clip.
- Counts clipped samples for host readout.
- Sits between the conditional adder output and the log2 gain input of the coarse gain-and-limiter.

---
 rtl/auto_gain_ranger.sv | 106 ++++++++++
 tb/tb_auto_gain_ranger.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/auto_gain_ranger.sv
// auto_gain_ranger: windowed peak-driven log2 gain select with clip counting for the coarse gain-and-limiter.
// Optional AUTO_GAIN_RANGER_FAST_ATTACK_EN: a clipping sample in MEASURE steps the gain down at once.
module auto_gain_ranger #(
  parameter int INPUT_WIDTH      = 16,
  parameter int OUTPUT_WIDTH     = 14,
  parameter int MAX_LOG2_GAIN    = 3,
  parameter int WIDTH_LOG2_GAIN  = 2,
  parameter int LOG2_WINDOW      = 10,
  parameter int HOLDOFF_WINDOWS  = 2,
  parameter int CLIP_COUNT_WIDTH = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        enable_i,
  input  logic [WIDTH_LOG2_GAIN-1:0]  manual_log2_gain_i,
  input  logic [INPUT_WIDTH-1:0]      data_i,
  input  logic                        clear_i,
  output logic [WIDTH_LOG2_GAIN-1:0]  log2_gain_o,
  output logic                        gain_change_o,
  output logic                        clip_o,
  output logic [CLIP_COUNT_WIDTH-1:0] clip_count_o
);
  localparam int SW = INPUT_WIDTH + MAX_LOG2_GAIN + 1;
  localparam int WIN = 2 ** LOG2_WINDOW;
  localparam int HOLD_N = HOLDOFF_WINDOWS * WIN;
  localparam int CW = $clog2(HOLD_N + WIN + 1) + 1;
  localparam logic [SW-1:0] FS = SW'(2 ** (OUTPUT_WIDTH - 1) - 1);
  localparam logic [SW-1:0] HALF = SW'(2 ** (OUTPUT_WIDTH - 2));
  localparam logic [WIDTH_LOG2_GAIN-1:0] GMAX = WIDTH_LOG2_GAIN'(MAX_LOG2_GAIN);
  typedef enum logic [1:0] {IDLE, MEASURE, DECIDE, HOLDOFF} state_t;
  state_t state, hold_next;
  logic [INPUT_WIDTH-1:0] mag, peak;
  logic [CW-1:0] cnt;
  logic [SW-1:0] scaled, pk_g, pk_g1;
  logic [WIDTH_LOG2_GAIN-1:0] manual_gain, next_gain;
  logic clip_now, go_down, go_up;
  // negating the most negative sample yields 2^(INPUT_WIDTH-1), which is exact as unsigned
  always_comb begin
    mag = data_i[INPUT_WIDTH-1] ? -data_i : data_i;
    scaled = SW'(mag) << log2_gain_o;
    clip_now = scaled > FS;
    pk_g = SW'(peak) << log2_gain_o;
    pk_g1 = pk_g << 1;
    go_down = pk_g > FS && log2_gain_o != '0;
    go_up = pk_g1 < HALF && log2_gain_o != GMAX;
    next_gain = go_down ? log2_gain_o - 1'b1 : go_up ? log2_gain_o + 1'b1 : log2_gain_o;
    manual_gain = int'(manual_log2_gain_i) > MAX_LOG2_GAIN ? GMAX : manual_log2_gain_i;
    hold_next = HOLD_N == 0 ? MEASURE : HOLDOFF;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      log2_gain_o <= '0;
      gain_change_o <= 1'b0;
      clip_o <= 1'b0;
      clip_count_o <= '0;
      peak <= '0;
      cnt <= '0;
    end else begin
      clip_o <= clip_now;
      clip_count_o <= clear_i ? '0 : (clip_now && ~&clip_count_o) ? clip_count_o + 1'b1 : clip_count_o;
      gain_change_o <= 1'b0;
      if (!enable_i) begin
        state <= IDLE;
        peak <= '0;
        cnt <= '0;
        if (state == IDLE) log2_gain_o <= manual_gain;
      end else begin
        case (state)
          IDLE: state <= MEASURE;
          MEASURE:
`ifdef AUTO_GAIN_RANGER_FAST_ATTACK_EN
            if (clip_now && log2_gain_o != '0) begin
              log2_gain_o <= log2_gain_o - 1'b1;
              gain_change_o <= 1'b1;
              peak <= '0;
              cnt <= '0;
              state <= hold_next;
            end else
`endif
            begin
              peak <= mag > peak ? mag : peak;
              cnt <= cnt + 1'b1;
              if (cnt == CW'(WIN - 1)) state <= DECIDE;
            end
          DECIDE: begin
            log2_gain_o <= next_gain;
            gain_change_o <= next_gain != log2_gain_o;
            peak <= '0;
            cnt <= '0;
            state <= next_gain != log2_gain_o ? hold_next : MEASURE;
          end
          HOLDOFF: begin
            cnt <= cnt + 1'b1;
            if (cnt == CW'(HOLD_N - 1)) begin
              cnt <= '0;
              peak <= '0;
              state <= MEASURE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_auto_gain_ranger.sv
// tb_auto_gain_ranger: directed tables, hand sequences and random stimulus against a window-queue reference model.
module tb_auto_gain_ranger;
  localparam int FS = 8191;
  localparam int HALF = 4096;
  localparam int WIN = 16;
  localparam int HOLD_N = 32;
  localparam int GMAXI = 3;
  localparam int CMAX = 15;
`ifdef AUTO_GAIN_RANGER_FAST_ATTACK_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam int MANUAL = 0, MEAS = 1, DEC = 2, HOLD = 3;
  logic clk, rst_n, en, clr;
  logic [1:0] man;
  logic [15:0] data;
  logic [1:0] gain;
  logic chg, clip;
  logic [3:0] cnt;
  int total, passed;
  int m_g, m_chg, m_clip, m_cnt, m_mode, hold_left;
  int win[$];
  typedef struct {
    logic e;
    logic [1:0] mn;
    int d;
    logic c;
    int g, ch, cl, cn;
  } vec_t;
  vec_t tbl[10];

  auto_gain_ranger #(
    .LOG2_WINDOW(4), .HOLDOFF_WINDOWS(2), .CLIP_COUNT_WIDTH(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .manual_log2_gain_i(man),
    .data_i(data), .clear_i(clr), .log2_gain_o(gain), .gain_change_o(chg),
    .clip_o(clip), .clip_count_o(cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_g = 0; m_chg = 0; m_clip = 0; m_cnt = 0; m_mode = MANUAL; hold_left = 0;
    win.delete();
  endtask

  task automatic model_step(input int e, input int mn, input int d, input int c);
    int a, pk, ng;
    bit clip_now;
    a = d < 0 ? -d : d;
    clip_now = (a << m_g) > FS;
    m_cnt = c != 0 ? 0 : (clip_now && m_cnt < CMAX) ? m_cnt + 1 : m_cnt;
    m_clip = int'(clip_now);
    m_chg = 0;
    if (e == 0) begin
      if (m_mode == MANUAL) m_g = mn > GMAXI ? GMAXI : mn;
      m_mode = MANUAL;
      win.delete();
    end else if (m_mode == MANUAL) begin
      m_mode = MEAS;
      win.delete();
    end else if (m_mode == MEAS) begin
      if (FAST && clip_now && m_g > 0) begin
        m_g--; m_chg = 1; win.delete(); m_mode = HOLD; hold_left = HOLD_N;
      end else begin
        win.push_back(a);
        if (win.size() == WIN) m_mode = DEC;
      end
    end else if (m_mode == DEC) begin
      pk = 0;
      foreach (win[k]) if (win[k] > pk) pk = win[k];
      ng = ((pk << m_g) > FS && m_g > 0) ? m_g - 1 :
           ((pk << (m_g + 1)) < HALF && m_g < GMAXI) ? m_g + 1 : m_g;
      win.delete();
      if (ng != m_g) begin
        m_g = ng; m_chg = 1; m_mode = HOLD; hold_left = HOLD_N;
      end else m_mode = MEAS;
    end else begin
      hold_left--;
      if (hold_left == 0) m_mode = MEAS;
    end
  endtask

  task automatic step(input logic e, input logic [1:0] mn, input int d, input logic c);
    en = e; man = mn; data = d[15:0]; clr = c;
    @(posedge clk);
    model_step(int'(e), int'(mn), d, int'(c));
    @(negedge clk);
    chk("model_gain", int'(gain), m_g);
    chk("model_chg", int'(chg), m_chg);
    chk("model_clip", int'(clip), m_clip);
    chk("model_cnt", int'(cnt), m_cnt);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_gain"}, int'(gain), 0);
    chk({nm, "_chg"}, int'(chg), 0);
    chk({nm, "_clip"}, int'(clip), 0);
    chk({nm, "_cnt"}, int'(cnt), 0);
  endtask

  initial begin
    int pulses, p0, p1, p2, amp, d;
    logic blk_en;
    total = 0; passed = 0;
    tbl[0] = '{1'b0, 2'd2, 0, 1'b0, 2, 0, 0, 0};
    tbl[1] = '{1'b0, 2'd3, 0, 1'b0, 3, 0, 0, 0};
    tbl[2] = '{1'b0, 2'd3, 1100, 1'b0, 3, 0, 1, 1};
    tbl[3] = '{1'b0, 2'd3, 1023, 1'b0, 3, 0, 0, 1};
    tbl[4] = '{1'b0, 2'd1, 4096, 1'b0, 1, 0, 1, 2};
    tbl[5] = '{1'b0, 2'd1, 4096, 1'b0, 1, 0, 1, 3};
    tbl[6] = '{1'b0, 2'd1, -4095, 1'b0, 1, 0, 0, 3};
    tbl[7] = '{1'b0, 2'd0, 0, 1'b1, 0, 0, 0, 0};
    tbl[8] = '{1'b0, 2'd2, -8192, 1'b0, 2, 0, 1, 1};
    tbl[9] = '{1'b0, 2'd2, 0, 1'b1, 2, 0, 0, 0};
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; man = 2'd0; data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_zero("por");
    rst_n = 1'b1;
    // reset while measuring with gain 2 and five clips counted
    step(1'b0, 2'd2, 0, 1'b0);
    repeat (5) step(1'b0, 2'd2, 5000, 1'b0);
    repeat (3) step(1'b1, 2'd2, 0, 1'b0);
    chk("pre_reset_gain", int'(gain), 2);
    chk("pre_reset_cnt", int'(cnt), 5);
    rst_n = 1'b0;
    model_reset();
    #2 check_zero("rst_async");
    @(posedge clk);
    @(negedge clk);
    check_zero("rst_held");
    rst_n = 1'b1;
    step(1'b0, 2'd1, 0, 1'b0);
    chk("post_reset_idle_gain", int'(gain), 1);
    foreach (tbl[i]) begin
      step(tbl[i].e, tbl[i].mn, tbl[i].d, tbl[i].c);
      chk($sformatf("tbl%0d_gain", i), int'(gain), tbl[i].g);
      chk($sformatf("tbl%0d_chg", i), int'(chg), tbl[i].ch);
      chk($sformatf("tbl%0d_clip", i), int'(clip), tbl[i].cl);
      chk($sformatf("tbl%0d_cnt", i), int'(cnt), tbl[i].cn);
    end
    // ramp up from gain 0 on a quiet +500 input
    step(1'b0, 2'd0, 0, 1'b1);
    pulses = 0; p0 = -1; p1 = -1; p2 = -1;
    for (int i = 1; i <= 200; i++) begin
      step(1'b1, 2'd0, 500, 1'b0);
      if (chg) begin
        if (pulses == 0) p0 = i;
        else if (pulses == 1) p1 = i;
        else if (pulses == 2) p2 = i;
        pulses++;
      end
    end
    chk("ramp_pulses", pulses, 3);
    chk("ramp_p0", p0, 18);
    chk("ramp_p1", p1, 67);
    chk("ramp_p2", p2, 116);
    chk("ramp_gain", int'(gain), 3);
    // loud +3000 input backs the gain off to 1
    pulses = 0;
    for (int i = 1; i <= 300; i++) begin
      step(1'b1, 2'd0, 3000, i == 1);
      if (i <= 30) chk("loud_clip", int'(clip), 1);
      if (chg) pulses++;
    end
    chk("loud_pulses", pulses, 2);
    chk("loud_gain", int'(gain), 1);
    chk("loud_cnt_sat", int'(cnt), 15);
    // full-scale negative at gain 0 clips but cannot go lower
    step(1'b0, 2'd0, 0, 1'b0);
    step(1'b0, 2'd0, 0, 1'b0);
    pulses = 0;
    for (int i = 1; i <= 60; i++) begin
      step(1'b1, 2'd0, -32768, 1'b0);
      if (chg) pulses++;
      chk("neg_clip", int'(clip), 1);
    end
    chk("neg_pulses", pulses, 0);
    chk("neg_gain", int'(gain), 0);
    chk("neg_cnt", int'(cnt), 15);
    step(1'b1, 2'd0, -32768, 1'b1);
    chk("clear_cnt", int'(cnt), 0);
    step(1'b1, 2'd0, -32768, 1'b0);
    chk("recount_cnt", int'(cnt), 1);
    // single spike at window sample 5, gain 3
    step(1'b0, 2'd3, 0, 1'b0);
    step(1'b0, 2'd3, 0, 1'b0);
    step(1'b1, 2'd3, 0, 1'b1);
    p0 = -1; p1 = -1; pulses = 0;
    for (int j = 0; j <= 80; j++) begin
      step(1'b1, 2'd3, j == 5 ? 2000 : 0, 1'b0);
      if (chg) begin
        if (pulses == 0) begin p0 = j; chk("spike_gain_down", int'(gain), 2); end
        else if (pulses == 1) begin p1 = j; chk("spike_gain_up", int'(gain), 3); end
        pulses++;
      end
    end
    chk("spike_first", p0, FAST ? 5 : 16);
    chk("spike_second", p1, (FAST ? 5 : 16) + 49);
    chk("spike_pulses", pulses, 2);
    // random traffic against the model
    amp = 0; blk_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) begin
        case ($urandom_range(5, 0))
          0: amp = 0;
          1: amp = 300;
          2: amp = 1200;
          3: amp = 3000;
          4: amp = 9000;
          default: amp = 32767;
        endcase
        blk_en = $urandom_range(7, 0) != 0;
      end
      if (i == 1500) begin
        rst_n = 1'b0;
        model_reset();
        #2 check_zero("rand_rst");
        @(negedge clk);
        rst_n = 1'b1;
      end
      d = int'($urandom_range(amp, 0));
      if ($urandom_range(1, 0) == 1) d = -d;
      if ($urandom_range(99, 0) == 0) d = -32768;
      step(blk_en && ($urandom_range(199, 0) != 0), 2'($urandom_range(3, 0)), d,
           $urandom_range(49, 0) == 0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
